// File: rtl/lane_conv_pkg.sv
// Shared defaults for the lane_conv family (lane_conv_1to4 / lane_conv_4to1).
package lane_conv_pkg;

    localparam int unsigned LC_DATA_W = 10;
    localparam int unsigned LC_LANES  = 4;

    // Width of a lane index; a single-lane build still needs a 1-bit counter.
    function automatic int unsigned lane_cnt_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/lane_conv_1to4.sv
// Packs a stream of DATA_W-bit pixels into LANES-wide words, LSB lane first.
// A word closes on its last lane or on a line-end pixel; short words are
// zero-padded and flagged through m_tkeep.
module lane_conv_1to4
    import lane_conv_pkg::*;
#(
    parameter int unsigned DATA_W = LC_DATA_W,
    parameter int unsigned LANES  = LC_LANES
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      aclken,
    input  logic                      s_tuser,
    input  logic                      s_tlast,
    input  logic [DATA_W-1:0]         s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic                      m_tuser,
    output logic                      m_tlast,
    output logic [LANES*DATA_W-1:0]   m_tdata,
    output logic [LANES-1:0]          m_tkeep,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      err_align
);

    localparam int unsigned WORD_W = LANES * DATA_W;
    localparam int unsigned LANE_W = lane_cnt_w(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] asm_buf;
    logic [WORD_W-1:0] asm_next;
    logic [LANES-1:0]  keep_next;
    logic              user_acc;
    logic              in_fire;
    logic              out_fire;
    logic              closing;

    // The output register is the only stage, so accept whenever it is free
    // or draining this cycle; deliberately not gated by aclken.
    assign s_tready  = !m_tvalid || m_tready;
    assign in_fire   = aclken && s_tvalid && s_tready;
    assign out_fire  = aclken && m_tvalid && m_tready;
    assign closing   = (lane == LAST_LANE) || s_tlast;
    // Frame start is only legal on lane 0; reported but otherwise ignored.
    assign err_align = in_fire && s_tuser && (lane != '0);

    // Merge the incoming pixel into its lane and build the keep mask for a close here.
    always_comb begin
        asm_next  = asm_buf;
        keep_next = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (LANE_W'(i) == lane) begin
                asm_next[i*DATA_W +: DATA_W] = s_tdata;
            end
            keep_next[i] = (LANE_W'(i) <= lane);
        end
    end

    // Assembly buffer, lane counter and output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lane     <= '0;
            asm_buf  <= '0;
            user_acc <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tuser  <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            // A closing word on the same edge overrides this clear, so no bubble.
            if (out_fire) begin
                m_tvalid <= 1'b0;
            end
            if (in_fire) begin
                if (closing) begin
                    m_tdata  <= asm_next;
                    m_tkeep  <= keep_next;
                    m_tuser  <= user_acc | s_tuser;
                    m_tlast  <= s_tlast;
                    m_tvalid <= 1'b1;
                    asm_buf  <= '0;
                    lane     <= '0;
                    user_acc <= 1'b0;
                end else begin
                    asm_buf  <= asm_next;
                    lane     <= lane + LANE_W'(1);
                    user_acc <= user_acc | s_tuser;
                end
            end
        end
    end

endmodule
